// File: rtl/rb1_serial_tx.sv
// rb1_serial_tx: reads 18 bytes from RB1, transposes them into 8 words of
// 18 bits and streams each word over the sen/sd link as a 21-bit frame
// (3-bit address then 18 data bits, MSB first), then raises S1_done.
// Optional build macro S1_SD_IDLE_LOW_EN: forces sd low whenever sen is high.
module rb1_serial_tx #(
    parameter int NUM_ENTRY = 18,
    parameter int NUM_WORD  = 8,
    parameter int GAP       = 2
) (
    input  logic       clk,
    input  logic       rst,
    output logic       RB1_RW,
    output logic [4:0] RB1_A,
    output logic [7:0] RB1_D,
    input  logic [7:0] RB1_Q,
    output logic       sen,
    output logic       sd,
    output logic       S1_done
);

    localparam logic [4:0] ENTRY_LAST = 5'(NUM_ENTRY - 1);
    localparam logic [4:0] ENTRY_END  = 5'(NUM_ENTRY);
    localparam logic [4:0] BIT_LAST   = 5'(NUM_ENTRY + 2);
    localparam logic [2:0] WORD_LAST  = 3'(NUM_WORD - 1);
    localparam logic [3:0] GAP_LAST   = 4'(GAP - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_SEND,
        S_GAP,
        S_DONE
    } state_t;

    state_t     state_reg, state_next;
    logic [4:0] entry_cnt_reg, entry_cnt_next;
    logic [4:0] bit_cnt_reg, bit_cnt_next;
    logic [3:0] gap_cnt_reg, gap_cnt_next;
    logic [2:0] word_idx_reg, word_idx_next;
    logic [4:0] addr_reg, addr_next;
    logic       sen_reg, sen_next;
    logic       sd_reg, sd_next;
    logic       done_reg, done_next;

    // One row per RB1 entry; row i bit k is bit i of word k.
    logic [7:0] rows_reg [NUM_ENTRY];
    logic       capture_en;

    logic [4:0] bit_idx_next;
    logic [4:0] data_idx;
    logic [2:0] word_inc;
    logic       next_bit;

    assign RB1_RW  = 1'b1;
    assign RB1_D   = 8'h00;
    assign RB1_A   = addr_reg;
    assign sen     = sen_reg;
    assign sd      = sd_reg;
    assign S1_done = done_reg;

    // Select the frame bit to be presented on the cycle after this one.
    always_comb begin
        bit_idx_next = bit_cnt_reg + 5'd1;
        data_idx     = BIT_LAST - bit_idx_next;
        word_inc     = word_idx_reg + 3'd1;
        if (bit_idx_next < 5'd3)
            next_bit = word_idx_reg[2'd2 - bit_idx_next[1:0]];
        else if (data_idx <= ENTRY_LAST)
            next_bit = rows_reg[data_idx][word_idx_reg];
        else
            next_bit = 1'b0;
    end

    // State and registered outputs; reset drops sen high immediately.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg     <= S_IDLE;
            entry_cnt_reg <= '0;
            bit_cnt_reg   <= '0;
            gap_cnt_reg   <= '0;
            word_idx_reg  <= '0;
            addr_reg      <= '0;
            sen_reg       <= 1'b1;
            sd_reg        <= 1'b0;
            done_reg      <= 1'b0;
        end else begin
            state_reg     <= state_next;
            entry_cnt_reg <= entry_cnt_next;
            bit_cnt_reg   <= bit_cnt_next;
            gap_cnt_reg   <= gap_cnt_next;
            word_idx_reg  <= word_idx_next;
            addr_reg      <= addr_next;
            sen_reg       <= sen_next;
            sd_reg        <= sd_next;
            done_reg      <= done_next;
        end
    end

    // Capture RB1 read data; the byte on RB1_Q belongs to the previous address.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NUM_ENTRY; i++)
                rows_reg[i] <= '0;
        end else if (capture_en) begin
            rows_reg[entry_cnt_reg - 5'd1] <= RB1_Q;
        end
    end

    // Next-state and next-output logic for the load/send/gap sequencer.
    always_comb begin
        state_next     = state_reg;
        entry_cnt_next = entry_cnt_reg;
        bit_cnt_next   = bit_cnt_reg;
        gap_cnt_next   = gap_cnt_reg;
        word_idx_next  = word_idx_reg;
        addr_next      = addr_reg;
        sen_next       = sen_reg;
        sd_next        = sd_reg;
        done_next      = done_reg;
        capture_en     = 1'b0;
        case (state_reg)
            S_IDLE: begin
                state_next     = S_LOAD;
                entry_cnt_next = '0;
                addr_next      = '0;
            end
            S_LOAD: begin
                capture_en = (entry_cnt_reg != 5'd0);
                if (entry_cnt_reg == ENTRY_END) begin
                    // Last entry captured this cycle; first frame starts next.
                    state_next    = S_SEND;
                    bit_cnt_next  = '0;
                    word_idx_next = '0;
                    sen_next      = 1'b0;
                    sd_next       = 1'b0;
                end else begin
                    entry_cnt_next = entry_cnt_reg + 5'd1;
                    addr_next      = (entry_cnt_reg < ENTRY_LAST) ?
                                     (entry_cnt_reg + 5'd1) : ENTRY_LAST;
                end
            end
            S_SEND: begin
                if (bit_cnt_reg == BIT_LAST) begin
                    state_next   = S_GAP;
                    gap_cnt_next = '0;
                    sen_next     = 1'b1;
`ifdef S1_SD_IDLE_LOW_EN
                    sd_next      = 1'b0;
`endif
                end else begin
                    bit_cnt_next = bit_cnt_reg + 5'd1;
                    sd_next      = next_bit;
                end
            end
            S_GAP: begin
                if (gap_cnt_reg == GAP_LAST) begin
                    if (word_idx_reg == WORD_LAST) begin
                        state_next = S_DONE;
                        done_next  = 1'b1;
                    end else begin
                        state_next    = S_SEND;
                        word_idx_next = word_inc;
                        bit_cnt_next  = '0;
                        sen_next      = 1'b0;
                        sd_next       = word_inc[2];
                    end
                end else begin
                    gap_cnt_next = gap_cnt_reg + 4'd1;
                end
            end
            S_DONE: begin
                done_next = 1'b1;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_rb1_serial_tx.sv
// Bench for rb1_serial_tx: RB1 memory model, link receiver monitor and a
// transposition reference model; randomized RB1 contents plus directed cases.
module tb_rb1_serial_tx;

    localparam int TB_GAP = 5;
    localparam int FLEN   = 21;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       RB1_RW;
    logic [4:0] RB1_A;
    logic [7:0] RB1_D;
    logic [7:0] RB1_Q = 8'h00;
    logic       sen, sd, S1_done;

    logic [7:0] ram [0:31];
    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    rb1_serial_tx #(.NUM_ENTRY(18), .NUM_WORD(8), .GAP(TB_GAP)) dut (
        .clk(clk), .rst(rst), .RB1_RW(RB1_RW), .RB1_A(RB1_A), .RB1_D(RB1_D),
        .RB1_Q(RB1_Q), .sen(sen), .sd(sd), .S1_done(S1_done)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    always @(posedge clk) RB1_Q <= ram[RB1_A];

    // Receiver-side monitor: collects frames, run lengths and gap sd levels.
    logic [20:0] frames_q [$];
    int          lows_q [$];
    int          gaps_q [$];
    logic        gap_and_q [$];
    logic        gap_or_q [$];
    int          low_run = 0, high_run = 0, first_fall = -1, done_at = -1;
    bit          in_gap = 0;
    logic [20:0] shreg = '0;
    logic        g_and = 1'b1, g_or = 1'b0;

    always @(negedge clk) begin
        if (!rst) begin
            frames_q.delete(); lows_q.delete(); gaps_q.delete();
            gap_and_q.delete(); gap_or_q.delete();
            low_run = 0; high_run = 0; in_gap = 0; shreg = '0;
            first_fall = -1; done_at = -1;
        end else if (sen === 1'b0) begin
            if (in_gap) begin
                gaps_q.push_back(high_run); gap_and_q.push_back(g_and);
                gap_or_q.push_back(g_or); in_gap = 0;
            end
            if (first_fall < 0) first_fall = cyc;
            low_run++;
            shreg = {shreg[19:0], sd};
        end else begin
            if (low_run > 0) begin
                frames_q.push_back(shreg); lows_q.push_back(low_run);
                low_run = 0; in_gap = 1; high_run = 0; g_and = 1'b1; g_or = 1'b0;
            end
            if (S1_done === 1'b1 && done_at < 0) begin
                done_at = cyc;
                if (in_gap) begin
                    gaps_q.push_back(high_run); gap_and_q.push_back(g_and);
                    gap_or_q.push_back(g_or); in_gap = 0;
                end
            end
            if (in_gap) begin
                high_run++; g_and = g_and & sd; g_or = g_or | sd;
            end
        end
    end

    // Reference: word k bit i = RB1[i][k]; frame = {k, word}.
    function automatic logic [20:0] exp_frame(input int k);
        logic [17:0] w;
        for (int i = 0; i < 18; i++) w[i] = ram[i][k];
        return {3'(k), w};
    endfunction

    task automatic apply_reset();
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic wait_done(input string tag);
        int n = 0;
        while (S1_done !== 1'b1 && n < 4000) begin
            @(negedge clk);
            n++;
        end
        total++;
        if (S1_done !== 1'b1) begin
            bad++;
            $display("FAIL %s done_timeout: S1_done=%b required 1", tag, S1_done);
        end
        repeat (3) @(negedge clk);
    endtask

    task automatic test_reset();
        logic [4:0] exp_a;
        @(negedge clk);
        #2 rst = 1'b0;
        #1;
        total++;
        if ({RB1_RW, RB1_A, RB1_D, sen, sd, S1_done} !== {1'b1, 5'd0, 8'd0, 1'b1, 1'b0, 1'b0}) begin
            bad++;
            $display("FAIL reset_values: got RW=%b A=%0d D=%h sen=%b sd=%b done=%b required 1 0 00 1 0 0",
                     RB1_RW, RB1_A, RB1_D, sen, sd, S1_done);
        end
        repeat (2) @(negedge clk);
        rst = 1'b1;
        for (int j = 0; j < 19; j++) begin
            @(negedge clk);
            exp_a = (j < 18) ? 5'(j) : 5'd17;
            total++;
            if ({RB1_RW, RB1_A, sen, sd} !== {1'b1, exp_a, 1'b1, 1'b0}) begin
                bad++;
                $display("FAIL load_seq[%0d]: RW=%b A=%0d sen=%b sd=%b required 1 %0d 1 0",
                         j, RB1_RW, RB1_A, sen, sd, exp_a);
            end
        end
        @(negedge clk);
        total++;
        if (sen !== 1'b0) begin
            bad++;
            $display("FAIL first_frame_start: sen=%b required 0", sen);
        end
        wait_done("reset_run");
    endtask

    task automatic test_pattern(input string name);
        apply_reset();
        wait_done(name);
        total++;
        if (frames_q.size() != 8) begin
            bad++;
            $display("FAIL %s frame_count: got %0d required 8", name, frames_q.size());
        end
        for (int k = 0; k < 8 && k < frames_q.size(); k++) begin
            total++;
            if (frames_q[k] !== exp_frame(k)) begin
                bad++;
                $display("FAIL %s frame[%0d]: got addr=%0d data=%h required addr=%0d data=%h",
                         name, k, frames_q[k][20:18], frames_q[k][17:0], k, exp_frame(k) & 21'h3FFFF);
            end
        end
        foreach (lows_q[i]) begin
            total++;
            if (lows_q[i] != FLEN) begin
                bad++;
                $display("FAIL %s sen_low_run[%0d]: got %0d required %0d", name, i, lows_q[i], FLEN);
            end
        end
        total++;
        if (gaps_q.size() != 8) begin
            bad++;
            $display("FAIL %s gap_count: got %0d required 8", name, gaps_q.size());
        end
        foreach (gaps_q[i]) begin
            total++;
            if (gaps_q[i] != TB_GAP) begin
                bad++;
                $display("FAIL %s gap_len[%0d]: got %0d required %0d", name, i, gaps_q[i], TB_GAP);
            end
        end
        total++;
        if (done_at - first_fall != 8 * (FLEN + TB_GAP)) begin
            bad++;
            $display("FAIL %s done_latency: got %0d required %0d", name, done_at - first_fall,
                     8 * (FLEN + TB_GAP));
        end
        repeat (10) @(negedge clk);
        total++;
        if ({S1_done, sen, RB1_A, RB1_RW, RB1_D} !== {1'b1, 1'b1, 5'd17, 1'b1, 8'd0}) begin
            bad++;
            $display("FAIL %s done_hold: done=%b sen=%b A=%0d RW=%b D=%h required 1 1 17 1 00",
                     name, S1_done, sen, RB1_A, RB1_RW, RB1_D);
        end
        $display("run %s: frames=%0d latency=%0d", name, frames_q.size(), done_at - first_fall);
    endtask

    task automatic test_mid_reset();
        int n = 0;
        for (int i = 0; i < 18; i++) ram[i] = 8'($urandom);
        apply_reset();
        while (sen !== 1'b0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        repeat (3 * (FLEN + TB_GAP) + 9) @(negedge clk);
        total++;
        if (sen !== 1'b0) begin
            bad++;
            $display("FAIL midrst_in_frame: sen=%b required 0", sen);
        end
        #2 rst = 1'b0;
        #1;
        total++;
        if ({sen, S1_done, RB1_A, sd} !== {1'b1, 1'b0, 5'd0, 1'b0}) begin
            bad++;
            $display("FAIL midrst_async: sen=%b done=%b A=%0d sd=%b required 1 0 0 0",
                     sen, S1_done, RB1_A, sd);
        end
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        total++;
        if (RB1_A !== 5'd0 || sen !== 1'b1) begin
            bad++;
            $display("FAIL midrst_restart: A=%0d sen=%b required 0 1", RB1_A, sen);
        end
        wait_done("mid_reset");
        total++;
        if (frames_q.size() != 8) begin
            bad++;
            $display("FAIL midrst_frame_count: got %0d required 8", frames_q.size());
        end
        for (int k = 0; k < 8 && k < frames_q.size(); k++) begin
            total++;
            if (frames_q[k] !== exp_frame(k)) begin
                bad++;
                $display("FAIL midrst_frame[%0d]: got %h required %h", k, frames_q[k], exp_frame(k));
            end
        end
        total++;
        if (done_at - first_fall != 8 * (FLEN + TB_GAP)) begin
            bad++;
            $display("FAIL midrst_latency: got %0d required %0d", done_at - first_fall,
                     8 * (FLEN + TB_GAP));
        end
        $display("run mid_reset: frames=%0d latency=%0d", frames_q.size(), done_at - first_fall);
    endtask

    task automatic test_sd_idle();
        logic exp_level;
        for (int i = 1; i < 18; i++) ram[i] = 8'($urandom);
        ram[0] = 8'hFF;
`ifdef S1_SD_IDLE_LOW_EN
        exp_level = 1'b0;
`else
        exp_level = 1'b1;
`endif
        apply_reset();
        wait_done("sd_idle");
        total++;
        if (gaps_q.size() != 8) begin
            bad++;
            $display("FAIL sd_idle gap_count: got %0d required 8", gaps_q.size());
        end
        foreach (gap_and_q[i]) begin
            total++;
            if ((exp_level ? gap_and_q[i] : gap_or_q[i]) !== exp_level) begin
                bad++;
                $display("FAIL sd_idle gap[%0d]: sd and=%b or=%b required all %b",
                         i, gap_and_q[i], gap_or_q[i], exp_level);
            end
        end
        total++;
        if (sd !== exp_level) begin
            bad++;
            $display("FAIL sd_idle done_level: sd=%b required %b", sd, exp_level);
        end
        $display("run sd_idle: gaps=%0d level=%b", gaps_q.size(), exp_level);
    endtask

    initial begin
        for (int i = 0; i < 32; i++) ram[i] = 8'h00;
        for (int i = 0; i < 18; i++) ram[i] = 8'hFF;
        test_reset();
        test_pattern("all_ff");
        for (int i = 0; i < 18; i++) ram[i] = 8'h01;
        test_pattern("all_01");
        for (int i = 0; i < 18; i++) ram[i] = 8'h00;
        ram[0]  = 8'h80;
        ram[17] = 8'h01;
        test_pattern("corners");
        for (int r = 0; r < 4; r++) begin
            for (int i = 0; i < 18; i++) ram[i] = 8'($urandom);
            test_pattern($sformatf("random%0d", r));
        end
        test_mid_reset();
        test_sd_idle();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
